// File: rtl/pec_wei_buf_pkg.sv
// Shared sizing and state encoding for the per-PEC weight receive buffer.
package pec_wei_buf_pkg;

  localparam int KERNEL_SIZE = 9;
  localparam int BLOCK_DEPTH = 32;
  localparam int DATA_WIDTH  = 8;
  localparam int BEAT_WORDS  = 8;

  localparam int FLG_W   = KERNEL_SIZE * BLOCK_DEPTH;
  localparam int NZ_W    = 9;
  localparam int ROWS    = FLG_W / BEAT_WORDS;
  localparam int CNT_W   = 6;
  localparam int BEAT_W  = 6;
  localparam int BEAT_SH = 3;
  localparam int POS_W   = 4;
  localparam int CH_W    = 5;
  localparam int ROW_W   = BEAT_WORDS * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FULL,
    ST_SERVE
  } bufState_t;

endpackage

// File: rtl/pec_wei_buf_flg_popcnt32.sv
// Population count of one kernel position's 32 sparsity flags.
module flg_popcnt32 (
  input  logic [31:0] flg,
  output logic [5:0]  cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'd0, flg[i]};
    end
  end

endmodule

// File: rtl/pec_wei_buf.sv
// Weight receive buffer: stores one compressed kernel, then serialises the
// non-zero weights of a requested position one per cycle with channel tags.
//
// state    | meaning
// ST_IDLE  | empty, waiting for ld_start
// ST_LOAD  | accepting compressed weight beats
// ST_FULL  | kernel held, waiting for mac_req / mac_rel
// ST_SERVE | streaming non-zero weights of one position
module pec_wei_buf
  import pec_wei_buf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_start,
  input  logic [FLG_W-1:0]      ld_flg,
  input  logic                  ld_wei_vld,
  input  logic [ROW_W-1:0]      ld_wei,
  output logic                  ld_wei_rdy,
  output logic                  ld_get,
  output logic                  rdy_mac,
  input  logic                  mac_req,
  input  logic [POS_W-1:0]      mac_pos,
  input  logic                  mac_rel,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_wei,
  output logic [CH_W-1:0]       out_ch,
  output logic                  out_last,
  output logic                  ser_done
);

  bufState_t state, stateNxt;

  logic [BLOCK_DEPTH-1:0] flgPos  [KERNEL_SIZE];
  logic [NZ_W-1:0]        base    [KERNEL_SIZE];
  logic [NZ_W-1:0]        baseNxt [KERNEL_SIZE];
  logic [CNT_W-1:0]       cntNxt  [KERNEL_SIZE];
  logic [NZ_W-1:0]        nzNxt;
  logic [BEAT_W-1:0]      beats, beatsNxt, beatCnt;
  logic [BLOCK_DEPTH-1:0] mask;
  logic [NZ_W-1:0]        rdPtr;
  logic                   badPend;
  logic [ROW_W-1:0]       mem [ROWS];
  logic [ROW_W-1:0]       rowData;
  logic [CH_W-1:0]        lowCh;
  logic                   maskOne;
  logic                   ldHs, lastBeat, reqOk;

  for (genvar p = 0; p < KERNEL_SIZE; p++) begin : g_pop
    flg_popcnt32 uPop (
      .flg(ld_flg[p*BLOCK_DEPTH +: BLOCK_DEPTH]),
      .cnt(cntNxt[p])
    );
  end

  // Prefix bases give each position's first slot in the packed weight store.
  always_comb begin
    nzNxt = '0;
    for (int p = 0; p < KERNEL_SIZE; p++) begin
      baseNxt[p] = nzNxt;
      nzNxt      = nzNxt + NZ_W'(cntNxt[p]);
    end
    beatsNxt = BEAT_W'((nzNxt + NZ_W'(BEAT_WORDS - 1)) >> BEAT_SH);
  end

  assign ldHs     = (state == ST_LOAD) && ld_wei_vld;
  assign lastBeat = ldHs && (beatCnt == beats - BEAT_W'(1));
  assign reqOk    = mac_req && (mac_pos < POS_W'(KERNEL_SIZE));
  assign maskOne  = (mask != '0) && ((mask & (mask - BLOCK_DEPTH'(1))) == '0);

  always_comb begin
    lowCh = '0;
    for (int i = BLOCK_DEPTH - 1; i >= 0; i--) begin
      if (mask[i]) lowCh = CH_W'(i);
    end
  end

  always_comb begin
    stateNxt   = state;
    ld_get     = 1'b0;
    ld_wei_rdy = 1'b0;
    rdy_mac    = 1'b0;
    out_vld    = 1'b0;
    ser_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ld_start) begin
          ld_get   = (nzNxt == '0);
          stateNxt = (nzNxt == '0) ? ST_FULL : ST_LOAD;
        end
      end
      ST_LOAD: begin
        ld_wei_rdy = 1'b1;
        if (lastBeat) begin
          ld_get   = 1'b1;
          stateNxt = ST_FULL;
        end
      end
      ST_FULL: begin
        rdy_mac = 1'b1;
        if (mac_rel) begin
          stateNxt = ST_IDLE;
        end else begin
          ser_done = badPend;
          if (reqOk) stateNxt = ST_SERVE;
        end
      end
      ST_SERVE: begin
        rdy_mac = 1'b1;
        out_vld = (mask != '0);
        if (mac_rel) begin
          stateNxt = ST_IDLE;
        end else if ((mask == '0) || (out_rdy && maskOne)) begin
          ser_done = 1'b1;
          stateNxt = ST_FULL;
        end
      end
      default: stateNxt = ST_IDLE;
    endcase
  end

  assign rowData  = mem[rdPtr[NZ_W-1:BEAT_SH]];
  assign out_wei  = out_vld ? rowData[rdPtr[BEAT_SH-1:0]*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign out_ch   = out_vld ? lowCh : '0;
  assign out_last = out_vld && maskOne;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      beats   <= '0;
      beatCnt <= '0;
      mask    <= '0;
      rdPtr   <= '0;
      badPend <= 1'b0;
      for (int p = 0; p < KERNEL_SIZE; p++) begin
        flgPos[p] <= '0;
        base[p]   <= '0;
      end
    end else begin
      state   <= stateNxt;
      badPend <= (state == ST_FULL) && mac_req && !mac_rel && !reqOk;
      if ((state == ST_IDLE) && ld_start) begin
        for (int p = 0; p < KERNEL_SIZE; p++) begin
          flgPos[p] <= ld_flg[p*BLOCK_DEPTH +: BLOCK_DEPTH];
          base[p]   <= baseNxt[p];
        end
        beats   <= beatsNxt;
        beatCnt <= '0;
      end else if (ldHs) begin
        beatCnt <= beatCnt + BEAT_W'(1);
      end
      if ((state == ST_FULL) && reqOk && !mac_rel) begin
        mask  <= flgPos[mac_pos];
        rdPtr <= base[mac_pos];
      end else if ((state == ST_SERVE) && out_vld && out_rdy) begin
        mask  <= mask & (mask - BLOCK_DEPTH'(1));
        rdPtr <= rdPtr + NZ_W'(1);
      end
    end
  end

  // Weight store has no reset; rows beyond the loaded count are never read.
  always_ff @(posedge clk) begin
    if (ldHs) mem[beatCnt] <= ld_wei;
  end

endmodule

// File: tb/tb_pec_wei_buf.sv
// Scoreboard bench for pec_wei_buf: expected weights queued per request, checked on handshake.
module tb_pec_wei_buf;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ld_start = 1'b0;
  logic [287:0] ld_flg = '0;
  logic         ld_wei_vld = 1'b0;
  logic [63:0]  ld_wei = '0;
  logic         ld_wei_rdy, ld_get, rdy_mac;
  logic         mac_req = 1'b0;
  logic [3:0]   mac_pos = '0;
  logic         mac_rel = 1'b0;
  logic         out_vld;
  logic         out_rdy = 1'b1;
  logic [7:0]   out_wei;
  logic [4:0]   out_ch;
  logic         out_last, ser_done;

  always #5 clk = ~clk;

  pec_wei_buf dut (
    .clk(clk), .rst_n(rst_n),
    .ld_start(ld_start), .ld_flg(ld_flg), .ld_wei_vld(ld_wei_vld), .ld_wei(ld_wei),
    .ld_wei_rdy(ld_wei_rdy), .ld_get(ld_get), .rdy_mac(rdy_mac),
    .mac_req(mac_req), .mac_pos(mac_pos), .mac_rel(mac_rel),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_wei(out_wei), .out_ch(out_ch),
    .out_last(out_last), .ser_done(ser_done)
  );

  typedef struct packed {
    logic [7:0] wei;
    logic [4:0] ch;
    logic       last;
  } expT;

  expT          expQ[$];
  int           nChecks = 0;
  int           nErrors = 0;
  int           hsCnt = 0;
  logic [7:0]   weiMem [288];
  logic [287:0] curFlg;
  logic         stallPrev = 1'b0;
  logic [7:0]   stallWei;
  logic [4:0]   stallCh;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    expT e;
    if (rst_n) begin
      if (stallPrev) begin
        chk("stall_vld", out_vld, 1);
        chk("stall_wei", out_wei, stallWei);
        chk("stall_ch", out_ch, stallCh);
      end
      if (out_vld && out_rdy) begin
        hsCnt++;
        if (expQ.size() == 0) chk("extra_out", 1, 0);
        else begin
          e = expQ.pop_front();
          chk("out_wei", out_wei, e.wei);
          chk("out_ch", out_ch, e.ch);
          chk("out_last", out_last, e.last);
        end
      end
      stallPrev = out_vld && !out_rdy;
      stallWei  = out_wei;
      stallCh   = out_ch;
    end else begin
      stallPrev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected stream of one position; returns its non-zero count.
  function automatic int pushPos(input int pos, input int limit);
    int base = 0;
    int n;
    int k = 0;
    logic [31:0] sl;
    if (pos >= 9) return 0;
    for (int q = 0; q < pos; q++) base += $countones(curFlg[q*32 +: 32]);
    sl = curFlg[pos*32 +: 32];
    n = $countones(sl);
    for (int c = 0; c < 32; c++) begin
      if (sl[c]) begin
        if (k < limit) expQ.push_back('{wei: weiMem[base+k], ch: 5'(c), last: (k == n-1)});
        k++;
      end
    end
    return n;
  endfunction

  task automatic loadKernel(input logic [287:0] flg, input int maxBeats, input bit stray);
    int nz;
    int beats;
    curFlg = flg;
    nz = $countones(flg);
    beats = (nz + 7) / 8;
    ld_flg = flg;
    ld_start = 1'b1;
    @(negedge clk);
    chk("ld_get_start", ld_get, (nz == 0));
    chk("rdy_mac_idle", rdy_mac, 0);
    tick();
    ld_start = 1'b0;
    for (int b = 0; b < beats && b < maxBeats; b++) begin
      for (int k = 0; k < 8; k++) ld_wei[k*8 +: 8] = (b*8+k < 288) ? weiMem[b*8+k] : 8'hEE;
      ld_wei_vld = 1'b1;
      if (stray && b == 2) begin
        ld_start = 1'b1;
        ld_flg = '0;
      end
      @(negedge clk);
      chk("ld_wei_rdy", ld_wei_rdy, 1);
      chk("ld_get_beat", ld_get, (b == beats-1));
      tick();
      ld_start = 1'b0;
      ld_flg = flg;
    end
    if (maxBeats >= beats) begin
      // Extra beat offered after the load must be refused.
      @(negedge clk);
      chk("rdy_mac_full", rdy_mac, 1);
      chk("ld_wei_rdy_full", ld_wei_rdy, 0);
      chk("ld_get_full", ld_get, 0);
      tick();
    end
    ld_wei_vld = 1'b0;
  endtask

  task automatic servePos(input int pos, input bit bp, input int relAt);
    int n;
    int cyc = 0;
    bit done = 0;
    int hs0 = hsCnt;
    n = pushPos(pos, (relAt < 0) ? 99 : relAt);
    mac_pos = 4'(pos);
    mac_req = 1'b1;
    out_rdy = 1'b1;
    tick();
    mac_req = 1'b0;
    if (relAt >= 0) begin
      repeat (relAt - 1) tick();
      mac_rel = 1'b1;
      @(negedge clk);
      chk("rel_no_done", ser_done, 0);
      tick();
      mac_rel = 1'b0;
      @(negedge clk);
      chk("rel_out_vld", out_vld, 0);
      chk("rel_rdy_mac", rdy_mac, 0);
      chk("rel_done_after", ser_done, 0);
      tick();
      chk("rel_hs_count", hsCnt - hs0, relAt);
      chk("rel_q_empty", expQ.size(), 0);
    end else begin
      for (int i = 0; i < 300 && !done; i++) begin
        out_rdy = bp ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
        @(negedge clk);
        if (ser_done) begin
          done = 1;
          cyc = i;
        end
        tick();
      end
      out_rdy = 1'b1;
      chk("ser_done_seen", done, 1);
      if (!bp) chk("latency", cyc, (n == 0) ? 0 : n - 1);
      chk("hs_count", hsCnt - hs0, n);
      chk("q_empty", expQ.size(), 0);
      @(negedge clk);
      chk("rdy_mac_after", rdy_mac, 1);
      chk("no_extra_done", ser_done, 0);
      chk("no_extra_vld", out_vld, 0);
      tick();
    end
    expQ.delete();
  endtask

  task automatic checkQuiet(input string tag);
    chk({tag, "_ld_wei_rdy"}, ld_wei_rdy, 0);
    chk({tag, "_ld_get"}, ld_get, 0);
    chk({tag, "_rdy_mac"}, rdy_mac, 0);
    chk({tag, "_out_vld"}, out_vld, 0);
    chk({tag, "_out_wei"}, out_wei, 0);
    chk({tag, "_out_ch"}, out_ch, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_ser_done"}, ser_done, 0);
  endtask

  task automatic relFull();
    mac_rel = 1'b1;
    mac_req = 1'b1;
    mac_pos = 4'd2;
    tick();
    mac_rel = 1'b0;
    mac_req = 1'b0;
    @(negedge clk);
    chk("relfull_rdy_mac", rdy_mac, 0);
    chk("relfull_out_vld", out_vld, 0);
    chk("relfull_done", ser_done, 0);
    tick();
  endtask

  task automatic sparseSetup(output logic [287:0] sp);
    sp = '0;
    sp[0] = 1'b1;
    sp[31] = 1'b1;
    sp[2*32 + 4] = 1'b1;
    weiMem[0] = 8'h11;
    weiMem[1] = 8'h22;
    weiMem[2] = 8'h33;
  endtask

  initial begin
    logic [287:0] ones = '1;
    logic [287:0] sp;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkQuiet("reset");
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 288; i++) weiMem[i] = 8'(i);
    loadKernel(ones, 99, 0);
    servePos(4, 0, -1);
    servePos(0, 1, -1);
    servePos(9, 0, -1);
    servePos(3, 0, 5);

    loadKernel(ones, 99, 1);
    servePos(8, 0, -1);
    relFull();

    sparseSetup(sp);
    loadKernel(sp, 99, 0);
    servePos(2, 0, -1);
    servePos(1, 0, -1);
    servePos(0, 0, -1);
    relFull();

    loadKernel('0, 99, 0);
    for (int p = 0; p < 9; p++) servePos(p, 0, -1);
    relFull();

    for (int i = 0; i < 288; i++) weiMem[i] = 8'(i);
    loadKernel(ones, 10, 0);
    ld_wei_vld = 1'b1;
    rst_n = 1'b0;
    #2;
    checkQuiet("midload_rst");
    tick();
    ld_wei_vld = 1'b0;
    rst_n = 1'b1;
    tick();
    sparseSetup(sp);
    loadKernel(sp, 99, 0);
    servePos(2, 0, -1);
    servePos(1, 0, -1);
    servePos(0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
